// File: rtl/ecpri_pkg.sv
// Shared constants and FSM state encoding for the eCPRI write-side scheduler.
package ecpri_pkg;

    localparam logic [3:0] ECPRI_REV    = 4'h1;
    // Revision in the upper nibble, reserved bits and C (concatenation) all zero.
    localparam logic [7:0] HDR_BYTE0    = {ECPRI_REV, 3'b000, 1'b0};
    localparam logic [7:0] HDR_SIZE_MSB = 8'h00;

    localparam logic [7:0] IQ_DATA = 8'h00;
    localparam logic [7:0] RT_CTRL = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_PAY,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/ecpri_wr_arb_rr_arbiter.sv
// Combinational round-robin picker: the first set request after ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   cand;
    logic [IW-1:0] slot;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        slot = '0;
        // i runs to N so that ptr itself is the last candidate considered.
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            slot = cand[IW-1:0];
            if (!any && req[slot]) begin
                any       = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/ecpri_wr_arb.sv
// Write-side scheduler for the shared eCPRI byte FIFO: round-robin message grant,
// 4-byte common header insertion, payload streaming and credit tracking from read pulses.
module ecpri_wr_arb
    import ecpri_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8,
    parameter int LW      = 4
) (
    input  logic                 inp_clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_type,
    input  logic [8*NUM_REQ-1:0] req_len,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_pop,
    input  logic                 fifo_rd,
    output logic [7:0]           inp_d,
    output logic                 write_flg,
    output logic [LW-1:0]        fifo_level,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 msg_done,
    output logic                 err_underrun,
    output wr_state_e            dbg_state
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wr_state_e            state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        g_idx;
    logic [IW-1:0]        arb_idx;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic                 arb_any;
    logic [7:0]           type_q;
    logic [7:0]           len_q;
    logic [7:0]           cnt;
    logic [7:0]           cur_data;
    logic                 take_ok;
    logic                 rd_ok;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Credit counts the byte already on its way (write_flg) as occupied.
    assign take_ok   = (fifo_level + LW'(write_flg)) < LW'(DEPTH);
    assign rd_ok     = fifo_rd && (fifo_level != '0);
    assign cur_data  = req_data[{g_idx, 3'b000} +: 8];
    assign req_pop   = ((state == ST_PAY) && take_ok) ? grant : '0;
    assign dbg_state = state;

    always_ff @(posedge inp_clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= IW'(NUM_REQ - 1);
            g_idx     <= '0;
            grant     <= '0;
            req_ack   <= '0;
            type_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            inp_d     <= '0;
            write_flg <= 1'b0;
            msg_done  <= 1'b0;
        end else begin
            write_flg <= 1'b0;
            req_ack   <= '0;
            msg_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        req_ack <= arb_gnt;
                        grant   <= arb_gnt;
                        g_idx   <= arb_idx;
                        rr_ptr  <= arb_idx;
                        type_q  <= req_type[{arb_idx, 3'b000} +: 8];
                        len_q   <= req_len[{arb_idx, 3'b000} +: 8];
                        cnt     <= '0;
                        state   <= ST_HDR0;
                    end
                end
                ST_HDR0: if (take_ok) begin
                    inp_d     <= HDR_BYTE0;
                    write_flg <= 1'b1;
                    state     <= ST_HDR1;
                end
                ST_HDR1: if (take_ok) begin
                    inp_d     <= type_q;
                    write_flg <= 1'b1;
                    state     <= ST_HDR2;
                end
                ST_HDR2: if (take_ok) begin
                    inp_d     <= HDR_SIZE_MSB;
                    write_flg <= 1'b1;
                    state     <= ST_HDR3;
                end
                ST_HDR3: if (take_ok) begin
                    inp_d     <= len_q;
                    write_flg <= 1'b1;
                    state     <= (len_q != 8'd0) ? ST_PAY : ST_DONE;
                end
                ST_PAY: if (take_ok) begin
                    inp_d     <= cur_data;
                    write_flg <= 1'b1;
                    cnt       <= cnt + 8'd1;
                    if (cnt == len_q - 8'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    msg_done <= 1'b1;
                    grant    <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write and a valid read in the same cycle cancel out.
    always_ff @(posedge inp_clk or negedge reset) begin
        if (!reset) begin
            fifo_level   <= '0;
            err_underrun <= 1'b0;
        end else begin
            if (write_flg && !rd_ok) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (!write_flg && rd_ok) begin
                fifo_level <= fifo_level - LW'(1);
            end
            if (fifo_rd && (fifo_level == '0)) begin
                err_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecpri_wr_arb.sv
// Directed bench for ecpri_wr_arb: header/payload stream, round-robin order, credit stall,
// level arithmetic, underrun flag, reset mid-message and request drop while granted.
module tb_ecpri_wr_arb;
  import ecpri_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int LW      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_type = '0;
  logic [8*NUM_REQ-1:0] req_len = '0;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_pop;
  logic                 fifo_rd = 1'b0;
  logic [7:0]           inp_d;
  logic                 write_flg;
  logic [LW-1:0]        fifo_level;
  logic [NUM_REQ-1:0]   grant;
  logic                 msg_done;
  logic                 err_underrun;
  wr_state_e            dbg_state;

  ecpri_wr_arb #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .LW(LW)) dut (
    .inp_clk      (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_type     (req_type),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .req_pop      (req_pop),
    .fifo_rd      (fifo_rd),
    .inp_d        (inp_d),
    .write_flg    (write_flg),
    .fifo_level   (fifo_level),
    .grant        (grant),
    .msg_done     (msg_done),
    .err_underrun (err_underrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- source model: byte k of source i is A0 + 16*i + k ----------------
  int pop_cnt [NUM_REQ] = '{default: 0};
  int base    [NUM_REQ] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[8*i +: 8] = 8'hA0 + 8'(16 * i) + 8'(pop_cnt[i] - base[i]);
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] wr_mem [256];
  int ack_log [64];
  int wr_cnt = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int max_level = 0;

  always @(negedge clk) begin
    if (write_flg) begin
      wr_mem[wr_cnt % 256] = inp_d;
      wr_cnt = wr_cnt + 1;
    end
    if (msg_done) done_cnt = done_cnt + 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i]) begin
        ack_log[ack_cnt % 64] = i;
        ack_cnt = ack_cnt + 1;
      end
    end
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_hdr(input logic [7:0] typ, input logic [7:0] len);
    exp_q.push_back(8'h10);
    exp_q.push_back(typ);
    exp_q.push_back(8'h00);
    exp_q.push_back(len);
  endtask

  task automatic push_pay(input int src, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back(8'hA0 + 8'(16 * src) + 8'(k));
  endtask

  task automatic check_stream(input string tag, input int start);
    chk({tag, "_count"}, 32'(wr_cnt - start), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      chk(tag, 32'(wr_mem[(start + k) % 256]), 32'(exp_q[k]));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      fifo_rd = 1'b1;
      tick();
    end
    fifo_rd = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [7:0] typ, input logic [7:0] len);
    req_type[8*i +: 8] = typ;
    req_len[8*i +: 8]  = len;
    base[i]            = pop_cnt[i];
  endtask

  task automatic wait_ack(input string tag, input logic [NUM_REQ-1:0] exp_ack);
    int c;
    c = 0;
    tick();
    while (req_ack == '0 && c < 40) begin
      tick();
      c++;
    end
    chk(tag, 32'(req_ack), 32'(exp_ack));
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int c;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < 200) begin
      tick();
      c++;
    end
    chk(tag, 32'(done_cnt - d0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    int c;
    int d0;
    int nrd;
    int p;
    int a0;

    // reset state
    tick();
    tick();
    chk("rst_write_flg", 32'(write_flg), 0);
    chk("rst_inp_d", 32'(inp_d), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_err", 32'(err_underrun), 0);
    chk("rst_msg_done", 32'(msg_done), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // single message, len 3, no reads
    set_src(0, RT_CTRL, 8'd3);
    req_valid = 4'b0001;
    s = wr_cnt;
    wait_ack("t1_ack", 4'b0001);
    req_valid = '0;
    chk("t1_grant", 32'(grant), 32'h1);
    tick();
    chk("t1_first_wf", 32'(write_flg), 1);
    chk("t1_first_byte", 32'(inp_d), 32'h10);
    wait_done("t1_done");
    chk("t1_level", 32'(fifo_level), 7);
    chk("t1_grant_idle", 32'(grant), 0);
    push_hdr(RT_CTRL, 8'd3);
    push_pay(0, 3);
    check_stream("t1_bytes", s);
    tick();
    chk("t1_done_one_cycle", 32'(msg_done), 0);

    // simultaneous read and write at level 5
    rd_pulses(2);
    chk("t4_level_5", 32'(fifo_level), 5);
    set_src(0, IQ_DATA, 8'd0);
    req_valid = 4'b0001;
    s = wr_cnt;
    wait_ack("t4_ack", 4'b0001);
    req_valid = '0;
    tick();
    chk("t4_wf", 32'(write_flg), 1);
    chk("t4_level_pre", 32'(fifo_level), 5);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("t4_level_rd_wr", 32'(fifo_level), 5);
    wait_done("t4_done");
    chk("t4_level_end", 32'(fifo_level), 8);
    push_hdr(IQ_DATA, 8'd0);
    check_stream("t4_bytes", s);

    // drain to zero, then underrun
    rd_pulses(8);
    chk("t4_drained", 32'(fifo_level), 0);
    chk("t4_no_err_yet", 32'(err_underrun), 0);
    rd_pulses(1);
    chk("t4_underrun", 32'(err_underrun), 1);
    chk("t4_level_stays_0", 32'(fifo_level), 0);

    // len 10 with full FIFO stall, then one read every 3 cycles
    set_src(2, IQ_DATA, 8'd10);
    req_valid = 4'b0100;
    s = wr_cnt;
    wait_ack("t3_ack", 4'b0100);
    req_valid = '0;
    repeat (20) tick();
    chk("t3_level_full", 32'(fifo_level), 8);
    chk("t3_writes_stall", 32'(wr_cnt - s), 8);
    chk("t3_wf_idle", 32'(write_flg), 0);
    chk("t3_state_pay", 32'(dbg_state), 32'(ST_PAY));
    chk("t3_grant_held", 32'(grant), 32'h4);
    d0 = done_cnt;
    nrd = 0;
    while (done_cnt == d0 && nrd < 12) begin
      p = wr_cnt;
      fifo_rd = 1'b1;
      tick();
      fifo_rd = 1'b0;
      tick();
      tick();
      nrd++;
      chk("t3_one_write_per_read", 32'(wr_cnt - p), 1);
    end
    chk("t3_reads", 32'(nrd), 6);
    chk("t3_max_level", 32'(max_level), 8);
    chk("t3_level_end", 32'(fifo_level), 8);
    push_hdr(IQ_DATA, 8'd10);
    push_pay(2, 10);
    check_stream("t3_bytes", s);

    // request dropped mid-message
    rd_pulses(8);
    fifo_rd = 1'b1;
    set_src(1, RT_CTRL, 8'd5);
    req_valid = 4'b0010;
    s = wr_cnt;
    wait_ack("t6_ack", 4'b0010);
    c = 0;
    while ((pop_cnt[1] - base[1]) < 2 && c < 20) begin
      tick();
      c++;
    end
    req_valid = '0;
    tick();
    chk("t6_grant_held", 32'(grant), 32'h2);
    wait_done("t6_done");
    fifo_rd = 1'b0;
    chk("t6_pops", 32'(pop_cnt[1] - base[1]), 5);
    chk("t6_level", 32'(fifo_level), 1);
    push_hdr(RT_CTRL, 8'd5);
    push_pay(1, 5);
    check_stream("t6_bytes", s);
    chk("t4_err_sticky", 32'(err_underrun), 1);
    rd_pulses(1);

    // reset during payload
    set_src(0, IQ_DATA, 8'd6);
    set_src(2, IQ_DATA, 8'd6);
    req_valid = 4'b0101;
    wait_ack("t5_ack", 4'b0100);
    c = 0;
    while ((pop_cnt[2] - base[2]) < 1 && c < 20) begin
      tick();
      c++;
    end
    chk("t5_in_pay", 32'(dbg_state), 32'(ST_PAY));
    reset = 1'b0;
    #1;
    chk("t5_rst_wf", 32'(write_flg), 0);
    chk("t5_rst_inp_d", 32'(inp_d), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_ack", 32'(req_ack), 0);
    chk("t5_rst_pop", 32'(req_pop), 0);
    chk("t5_rst_level", 32'(fifo_level), 0);
    chk("t5_rst_err", 32'(err_underrun), 0);
    chk("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset = 1'b1;
    tick();
    chk("t5_first_ack", 32'(req_ack), 32'h1);
    chk("t5_first_grant", 32'(grant), 32'h1);
    req_valid = '0;

    // all four sources, len 0, reads every cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 8'h20 + 8'(i), 8'd0);
    fifo_rd = 1'b1;
    s = wr_cnt;
    a0 = ack_cnt;
    req_valid = 4'b1111;
    c = 0;
    while ((ack_cnt - a0) < 5 && c < 80) begin
      tick();
      c++;
    end
    req_valid = '0;
    chk("t2_ack_count", 32'(ack_cnt - a0), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t2_grant_order", 32'(ack_log[(a0 + k) % 64]), 32'(k % 4));
    end
    wait_done("t2_done_last");
    fifo_rd = 1'b0;
    for (int k = 0; k < 5; k++) push_hdr(8'h20 + 8'(k % 4), 8'd0);
    check_stream("t2_bytes", s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecpri_wr_arb.md
Name: ecpri_wr_arb

Overview:
- Write-side scheduler for the shared 8-entry eCPRI byte FIFO.
- Arbitrates round-robin between NUM_REQ message sources. The grant is held for a whole message.
- Prepends the 4-byte eCPRI common header, then streams the granted source's payload into the FIFO write port (inp_d/write_flg).
- Tracks FIFO occupancy from read pulses, because the FIFO has no full or empty flags. Sits in the inp_clk domain, directly in front of the FIFO.

Parameters:
NUM_REQ, 4, number of message sources (2..8)
DEPTH, 8, FIFO entries; must equal the physical FIFO depth
LW, 4, width of fifo_level (holds 0..DEPTH)

Ports:
inp_clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  source i has a message descriptor ready
req_type  in  8*NUM_REQ  eCPRI message type, source i in bits [8i+7:8i]
req_len  in  8*NUM_REQ  payload length in bytes (0..255)
req_data  in  8*NUM_REQ  show-ahead payload byte; valid whenever the source is granted
req_ack  out  NUM_REQ  one-cycle pulse: descriptor accepted
req_pop  out  NUM_REQ  payload byte consumed this cycle (combinational)
fifo_rd  in  1  one pulse per byte read from the FIFO (inp_clk domain)
inp_d  out  8  FIFO write data (registered)
write_flg  out  1  FIFO write strobe (registered)
fifo_level  out  LW  current occupancy
grant  out  NUM_REQ  one-hot owner of the write port, 0 when idle
msg_done  out  1  one-cycle pulse after the last byte of a message is written
err_underrun  out  1  sticky: fifo_rd seen at level 0

Behaviour:
- Reset (reset==0, asynchronous): every output is 0, FSM goes to IDLE, rr_ptr=NUM_REQ-1 so source 0 wins first, err_underrun is cleared. Reset mid-message abandons the message; the source's descriptor is not re-acked.
- FSM states: IDLE, HDR0, HDR1, HDR2, HDR3, PAY, DONE.
- IDLE, any req_valid set:
  - Pick the first set bit searching from rr_ptr+1 upward with wrap.
  - Pulse req_ack[g]; latch type and len; set grant; rr_ptr<=g; go to HDR0.
- "Take" means the FSM commits one byte: inp_d<=byte, write_flg<=1 on the next edge.
- Take is allowed only when credit>0, where credit = DEPTH - fifo_level - write_flg. A take that cannot happen stalls the state.
- Header bytes:
  - HDR0 = 8'h10 (revision 1, reserved 0, C=0).
  - HDR1 = type.
  - HDR2 = 8'h00 (payload size MSB).
  - HDR3 = len.
- After HDR3: go to PAY if len>0, otherwise go to DONE.
- PAY:
  - On each take, req_pop[g]=1 in the same cycle and inp_d<=req_data[g].
  - A byte counter counts up to len; the last take goes to DONE.
- DONE: msg_done=1 for one cycle; clear grant; return to IDLE. The next arbitration can therefore happen at the earliest 1 cycle after DONE.
- write_flg is 0 in any cycle that follows a non-take cycle.
- fifo_level:
  - +1 when write_flg=1.
  - -1 when fifo_rd=1 and level>0.
  - Both in the same cycle: level unchanged.
  - fifo_rd at level 0: level stays 0 and err_underrun is set.
- Level never exceeds DEPTH.
- req_valid dropping while granted is ignored; the message always completes.
- Latency: descriptor accepted to first write_flg is 2 cycles with no backpressure. Each message costs len+4 writes plus 2 overhead cycles.

Decomposition:
- Package ecpri_pkg:
  - ECPRI_REV=4'h1
  - header byte constants
  - FSM state enum
  - message type constants: IQ_DATA=8'h00, RT_CTRL=8'h02
- One sub-module, rr_arbiter: NUM_REQ-wide request vector plus pointer in, one-hot grant plus index out, purely combinational.
- Credit counter and FSM stay in ecpri_wr_arb.

Test Plan:
1. Reset, then req_valid[0]=1, type=8'h02, len=3, data A,B,C, no reads -> write_flg bytes 10,02,00,03,A,B,C; msg_done pulse; fifo_level=7; grant returns to 0.
2. All four req_valid held, len=0, fifo_rd every cycle -> grants in order 0,1,2,3,0; each message writes exactly 4 bytes.
3. len=10, no fifo_rd -> writes stop at fifo_level=8. Then one fifo_rd pulse every 3 cycles -> exactly one write per read; level never exceeds 8; all 14 bytes are written in order.
4. fifo_rd and write_flg in the same cycle at level 5 -> level stays 5. fifo_rd at level 0 -> err_underrun=1 and stays set until reset.
5. Reset asserted during PAY of a len=6 message -> all outputs 0 immediately. After release, the pending requests on sources 0 and 2 grant source 0 first.
6. req_valid[1] dropped mid-message -> message still completes with len+4 writes, and req_pop[1] pulses exactly len times.
